// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU datapath types: machine word, instruction field widths and the
// next-PC source selector used by the fetch unit.
//   word_t       32-bit machine word
//   IMM_W        width of the branch immediate field (words)
//   ADDR_W       width of the absolute jump target field (words)
//   pc_sel_t     next-PC source, listed in priority order
// -----------------------------------------------------------------------------
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int IMM_W  = 16;
  localparam int ADDR_W = 26;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    HOLD,
    REG,
    JUMP,
    BRANCH,
    SEQ
  } pc_sel_t;

  // Word offset -> byte offset, sign-extended to a full word.
  function automatic word_t branch_offset(input logic [IMM_W-1:0] imm);
    return {{(WORD_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ras_stack.sv
// -----------------------------------------------------------------------------
// ras_stack
// Circular return-address stack. A push when full overwrites the oldest entry
// and the count saturates at DEPTH; a pop on an empty stack is ignored.
// Push and pop are never requested together by the parent.
//   CLK, nRST   clock, asynchronous active-low reset
//   push, pop   stack operations for this cycle
//   din         return address to push
//   top         most recently pushed entry (valid only when count > 0)
//   count       number of valid entries, 0..DEPTH
// Parameter DEPTH: entry count, power of two, 2..16.
// -----------------------------------------------------------------------------
module ras_stack
  import cpu_types_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          push,
  input  logic          pop,
  input  word_t         din,
  output word_t         top,
  output logic [CW-1:0] count
);

  word_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] top_ptr;

  // DEPTH is a power of two, so the pointer wraps for free; writing at
  // wr_ptr when full lands on the oldest entry.
  assign top_ptr = wr_ptr - PW'(1);
  assign top     = mem[top_ptr];

  // NOTE: the storage array is deliberately left out of reset; count gates
  // every use of top, so stale entries are never observed.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= din;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PW'(1);
      if (count != CW'(DEPTH)) count <= count + CW'(1);
    end else if (pop && (count != '0)) begin
      wr_ptr <= top_ptr;
      count  <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_ras_unit.sv
// -----------------------------------------------------------------------------
// pc_ras_unit
// Program counter with next-PC selection (halt / register jump / absolute
// jump / conditional branch / sequential) and an optional return-address
// stack that predicts return targets.
// Optional feature macro: PC_RAS_UNIT_RAS_EN
//   defined   -> Jump&Link pushes pc_plus, RegToPc&Ret pops the predicted
//                return target and flags a mispredict against rdat.
//   undefined -> no RAS storage, Ret ignored, ras_count/ras_mispredict = 0.
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   wen                  PC update enable (ihit & ~stall)
//   BrEq, BrNeq          conditional branch controls; alu_zero ALU flag
//   imm                  branch offset in words
//   Jump, addr           absolute jump and its word target field
//   Link                 Jump is a call (push return address)
//   RegToPc, Ret, rdat   register jump, return qualifier, register value
//   Halt                 halt request
//   cpc, pc_plus         current PC and cpc + 4
//   halted               sticky halt status
//   ras_count            valid RAS entries
//   ras_mispredict       one-cycle pulse after a wrong return prediction
// -----------------------------------------------------------------------------
module pc_ras_unit
  import cpu_types_pkg::*;
#(
  parameter word_t RESET_PC  = 32'h0000_0000,
  parameter int    RAS_DEPTH = 4,
  localparam int   CW        = $clog2(RAS_DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              wen,
  input  logic              BrEq,
  input  logic              BrNeq,
  input  logic              alu_zero,
  input  logic [IMM_W-1:0]  imm,
  input  logic              Jump,
  input  logic [ADDR_W-1:0] addr,
  input  logic              Link,
  input  logic              RegToPc,
  input  logic              Ret,
  input  word_t             rdat,
  input  logic              Halt,
  output word_t             cpc,
  output word_t             pc_plus,
  output logic              halted,
  output logic [CW-1:0]     ras_count,
  output logic              ras_mispredict
);

  pc_sel_t sel;
  word_t   next_pc;
  word_t   reg_target;
  logic    advance;
  logic    taken;

  assign pc_plus = cpc + 32'd4;
  assign advance = wen & ~halted;
  assign taken   = (BrEq & alu_zero) | (BrNeq & ~alu_zero);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sel = SEQ;
    if      (Halt)    sel = HOLD;
    else if (RegToPc) sel = REG;
    else if (Jump)    sel = JUMP;
    else if (taken)   sel = BRANCH;
  end

  always_comb begin
    next_pc = pc_plus;
    case (sel)
      HOLD:    next_pc = cpc;
      REG:     next_pc = reg_target;
      JUMP:    next_pc = {pc_plus[31:28], addr, 2'b00};
      BRANCH:  next_pc = pc_plus + branch_offset(imm);
      default: next_pc = pc_plus;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cpc    <= RESET_PC;
      halted <= 1'b0;
    end else if (advance) begin
      cpc <= next_pc;
      if (Halt) halted <= 1'b1;
    end
  end

`ifdef PC_RAS_UNIT_RAS_EN
  logic  push;
  logic  pop;
  word_t ras_top;

  // Push/pop follow the winning selector, so Halt or a concurrent RegToPc
  // suppresses a call push, and halted (advance=0) freezes the stack.
  assign push       = advance & (sel == JUMP) & Link;
  assign pop        = advance & (sel == REG) & Ret & (ras_count != '0);
  // The prediction is used even when wrong; the datapath flushes on mispredict.
  assign reg_target = pop ? ras_top : rdat;

  ras_stack #(
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK   (CLK),
    .nRST  (nRST),
    .push  (push),
    .pop   (pop),
    .din   (pc_plus),
    .top   (ras_top),
    .count (ras_count)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) ras_mispredict <= 1'b0;
    else       ras_mispredict <= pop & (ras_top != rdat);
  end
`else
  logic unused_ras_ctrl;

  assign reg_target      = rdat;
  assign ras_count       = '0;
  assign ras_mispredict  = 1'b0;
  assign unused_ras_ctrl = Link ^ Ret;
`endif

endmodule

// File: tb/tb_pc_ras_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_ras_unit
// Self-checking bench for pc_ras_unit. A behavioural model (queue-based
// stack) predicts the state after each edge; predictions are queued when the
// stimulus is driven and compared once the DUT has clocked.
// Works with and without PC_RAS_UNIT_RAS_EN.
// -----------------------------------------------------------------------------
module tb_pc_ras_unit;
  import cpu_types_pkg::*;

  localparam int    DEPTH  = 4;
  localparam word_t RST_PC = 32'h0000_0000;

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic              wen, BrEq, BrNeq, alu_zero, Jump, Link, RegToPc, Ret, Halt;
  logic [IMM_W-1:0]  imm;
  logic [ADDR_W-1:0] addr;
  word_t             rdat;
  word_t             cpc, pc_plus;
  logic              halted;
  logic [2:0]        ras_count;
  logic              ras_mispredict;

  typedef struct {
    word_t cpc;
    logic  halted;
    int    count;
    logic  mis;
  } exp_t;

  exp_t  exp_q[$];
  word_t m_stack[$];
  word_t m_pc;
  logic  m_halted;
  int    errors = 0;
  int    checks = 0;

  pc_ras_unit #(
    .RESET_PC  (RST_PC),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .wen            (wen),
    .BrEq           (BrEq),
    .BrNeq          (BrNeq),
    .alu_zero       (alu_zero),
    .imm            (imm),
    .Jump           (Jump),
    .addr           (addr),
    .Link           (Link),
    .RegToPc        (RegToPc),
    .Ret            (Ret),
    .rdat           (rdat),
    .Halt           (Halt),
    .cpc            (cpc),
    .pc_plus        (pc_plus),
    .halted         (halted),
    .ras_count      (ras_count),
    .ras_mispredict (ras_mispredict)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wen = 1'b1; BrEq = 1'b0; BrNeq = 1'b0; alu_zero = 1'b0; imm = '0;
    Jump = 1'b0; addr = '0; Link = 1'b0; RegToPc = 1'b0; Ret = 1'b0;
    rdat = '0; Halt = 1'b0;
  endtask

  task automatic model_reset();
    m_pc = RST_PC;
    m_halted = 1'b0;
    m_stack.delete();
    exp_q.delete();
  endtask

  // Predict the post-edge state from the currently driven inputs, clock once,
  // then compare against the oldest prediction.
  task automatic step();
    exp_t  e;
    word_t plus, nxt;
    logic  mis;
    int    off;
    plus = m_pc + 32'd4;
    nxt  = m_pc;
    mis  = 1'b0;
    if (wen && !m_halted) begin
      if (Halt) begin
        nxt = m_pc;
        m_halted = 1'b1;
      end else if (RegToPc) begin
        nxt = rdat;
`ifdef PC_RAS_UNIT_RAS_EN
        if (Ret && m_stack.size() > 0) begin
          nxt = m_stack.pop_back();
          mis = (nxt != rdat);
        end
`endif
      end else if (Jump) begin
        nxt = {plus[31:28], addr, 2'b00};
`ifdef PC_RAS_UNIT_RAS_EN
        if (Link) begin
          m_stack.push_back(plus);
          if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
        end
`endif
      end else if ((BrEq && alu_zero) || (BrNeq && !alu_zero)) begin
        off = int'($signed(imm)) * 4;
        nxt = plus + word_t'(off);
      end else begin
        nxt = plus;
      end
    end
    m_pc     = nxt;
    e.cpc    = m_pc;
    e.halted = m_halted;
    e.count  = m_stack.size();
    e.mis    = mis;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    check("cpc", cpc, e.cpc);
    check("pc_plus", pc_plus, e.cpc + 32'd4);
    check("halted", 32'(halted), 32'(e.halted));
    check("ras_count", 32'(ras_count), e.count);
    check("ras_mispredict", 32'(ras_mispredict), 32'(e.mis));
  endtask

  task automatic do_jump(input logic [ADDR_W-1:0] a, input logic lnk);
    idle(); Jump = 1'b1; addr = a; Link = lnk;
    step();
  endtask

  task automatic do_ret(input word_t r);
    idle(); RegToPc = 1'b1; Ret = 1'b1; rdat = r;
    step();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cpc"}, cpc, RST_PC);
    check({tag, "_pc_plus"}, pc_plus, RST_PC + 32'd4);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_ras_count"}, 32'(ras_count), 32'd0);
    check({tag, "_ras_mispredict"}, 32'(ras_mispredict), 32'd0);
  endtask

  initial begin
    idle();
    wen = 1'b0;
    model_reset();
    #12;
    check_reset_state("rst");
    @(negedge CLK);
    nRST = 1'b1;

    // Sequential fetch: 0 -> 4 -> 8 -> 12.
    idle();
    repeat (3) step();
    check("seq_12", cpc, 32'h0000_000C);

    // Absolute jump then branches.
    do_jump(26'h40, 1'b0);
    check("jump_100", cpc, 32'h0000_0100);
    idle(); BrNeq = 1'b1; alu_zero = 1'b0; imm = 16'hFFFE; step();
    check("bne_back", cpc, 32'h0000_00FC);
    idle(); BrEq = 1'b1; alu_zero = 1'b0; imm = 16'h0005; step();
    idle(); BrEq = 1'b1; alu_zero = 1'b1; imm = 16'h0003; step();
    idle(); BrNeq = 1'b1; alu_zero = 1'b1; imm = 16'h0007; step();

    // wen=0: nothing moves, no push.
    idle(); wen = 1'b0; Jump = 1'b1; Link = 1'b1; addr = 26'h123; step();

    // Call / correct return.
    do_jump(26'h10, 1'b0);
    do_jump(26'h100, 1'b1);
    check("call_400", cpc, 32'h0000_0400);
    do_ret(32'h0000_0044);
    check("ret_44", cpc, 32'h0000_0044);

    // Five calls into a 4-deep stack: oldest return address is lost.
    do_jump(26'h0, 1'b0);
    do_jump(26'h4, 1'b1);
    do_jump(26'h8, 1'b1);
    do_jump(26'hC, 1'b1);
    do_jump(26'h10, 1'b1);
    do_jump(26'h20, 1'b1);
`ifdef PC_RAS_UNIT_RAS_EN
    check("ras_full", 32'(ras_count), 32'd4);
`endif
    do_ret(32'h0000_0044);
    do_ret(32'h0000_0034);
    do_ret(32'h0000_0024);
    do_ret(32'h0000_0014);
    check("ret4_14", cpc, 32'h0000_0014);
    do_ret(32'h0000_0200);
    check("ret_empty", cpc, 32'h0000_0200);

    // Wrong prediction: redirect uses the stack top, pulse for one cycle.
    do_jump(26'h10, 1'b0);
    do_jump(26'h100, 1'b1);
    do_ret(32'h0000_0080);
`ifdef PC_RAS_UNIT_RAS_EN
    check("mis_target", cpc, 32'h0000_0044);
    check("mis_pulse", 32'(ras_mispredict), 32'd1);
`endif
    idle(); step();

    // RegToPc beats Jump&Link; no push happens.
    idle(); RegToPc = 1'b1; Jump = 1'b1; Link = 1'b1; addr = 26'h55; rdat = 32'h0000_0300; step();
    check("reg_wins", cpc, 32'h0000_0300);
    do_ret(32'h0000_0500);

    // Halt without wen is ignored, then a real halt freezes everything.
    idle(); wen = 1'b0; Halt = 1'b1; step();
    do_jump(26'h10, 1'b1);
    idle(); Halt = 1'b1; step();
    check("halt_set", 32'(halted), 32'd1);
    for (int i = 0; i < 10; i++) begin
      idle();
      if (i % 2 == 0) begin Jump = 1'b1; Link = 1'b1; addr = 26'(i + 1); end
      else begin RegToPc = 1'b1; Ret = 1'b1; rdat = 32'h0000_0900; end
      step();
    end
    check("halt_frozen", cpc, 32'h0000_0040);

    // Asynchronous reset mid-cycle, with a redirect pending.
    idle(); Jump = 1'b1; addr = 26'h3FF;
    #2;
    nRST = 1'b0;
    #1;
    check_reset_state("async_rst");
    model_reset();
    @(posedge CLK);
    #1;
    check("rst_hold_cpc", cpc, RST_PC);
    @(negedge CLK);
    nRST = 1'b1;
    idle();
    repeat (2) step();
    check("post_rst_seq", cpc, 32'h0000_0008);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
